// File: rtl/activation_lut_loader.sv
// Activation LUT write-side loader: streams LUT_DEPTH entries into BRAM, then
// reads the table back and compares the readback sum with the load sum.
module activation_lut_loader #(
  parameter int unsigned LUT_ADDR_SIZE = 10,
  parameter int unsigned LUT_DEPTH     = 1 << LUT_ADDR_SIZE,
  parameter int unsigned LUT_WIDTH     = 9,
  parameter int unsigned SUM_WIDTH     = LUT_WIDTH + LUT_ADDR_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [LUT_WIDTH-1:0]     in_data,
  output logic                     in_ready,
  output logic                     bram_we,
  output logic [LUT_ADDR_SIZE-1:0] bram_waddr,
  output logic [LUT_WIDTH-1:0]     bram_wdata,
  output logic                     bram_re,
  output logic [LUT_ADDR_SIZE-1:0] bram_raddr,
  input  logic [LUT_WIDTH-1:0]     bram_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [SUM_WIDTH-1:0]     checksum
);

  localparam int unsigned CNT_W = LUT_ADDR_SIZE + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(LUT_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LUT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]     wcnt;
  logic [CNT_W-1:0]     rcnt;
  logic [SUM_WIDTH-1:0] rsum;
  logic [SUM_WIDTH-1:0] rsum_next;
  logic                 re_d;
  logic                 accept;
  logic                 last_accept;
  logic                 load_go;
  logic                 verify_end;

  assign in_ready    = (state == S_LOAD);
  assign busy        = (state == S_LOAD) || (state == S_VERIFY) || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  assign accept      = in_ready & in_valid;
  assign last_accept = accept && (wcnt == LAST_IDX);
  assign load_go     = start && ((state == S_IDLE) || (state == S_DONE));
  assign verify_end  = (state == S_VERIFY) && (rcnt == DEPTH_CNT);

  // Read data trails bram_re by one cycle, so accumulation keys off the delayed enable.
  assign rsum_next = re_d ? (rsum + SUM_WIDTH'(bram_rdata)) : rsum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (load_go)     state_next = S_LOAD;
      S_LOAD:   if (last_accept) state_next = S_VERIFY;
      S_VERIFY: if (verify_end)  state_next = S_DRAIN;
      S_DRAIN:                   state_next = S_DONE;
      S_DONE:   if (load_go)     state_next = S_LOAD;
      default:                   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt       <= '0;
      rcnt       <= '0;
      rsum       <= '0;
      re_d       <= 1'b0;
      checksum   <= '0;
      error      <= 1'b0;
      bram_we    <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
      bram_re    <= 1'b0;
      bram_raddr <= '0;
    end else begin
      bram_we <= accept;
      re_d    <= bram_re;
      rsum    <= rsum_next;

      if (accept) begin
        bram_waddr <= wcnt[LUT_ADDR_SIZE-1:0];
        bram_wdata <= in_data;
        checksum   <= checksum + SUM_WIDTH'(in_data);
        wcnt       <= wcnt + CNT_ONE;
      end

      if (load_go) begin
        wcnt     <= '0;
        rcnt     <= '0;
        rsum     <= '0;
        checksum <= '0;
        error    <= 1'b0;
        bram_re  <= 1'b0;
      end

      // The read sweep is launched on the final handshake so address 0 is read
      // while the last write (address LUT_DEPTH-1) lands.
      if (last_accept) begin
        bram_re    <= 1'b1;
        bram_raddr <= '0;
        rcnt       <= CNT_ONE;
      end else if (state == S_VERIFY) begin
        if (rcnt == DEPTH_CNT) begin
          bram_re <= 1'b0;
        end else begin
          bram_raddr <= rcnt[LUT_ADDR_SIZE-1:0];
          rcnt       <= rcnt + CNT_ONE;
        end
      end

      if (state == S_DRAIN) begin
        error <= (rsum_next != checksum);
      end
    end
  end

endmodule

// File: tb/tb_activation_lut_loader.sv
// Bench for activation_lut_loader: timeline-based reference model, BRAM model
// with optional readback corruption, directed and randomized load streams.
module tb_activation_lut_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned W     = 9;
  localparam int unsigned SW    = W + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          bram_we;
  logic [AW-1:0] bram_waddr;
  logic [W-1:0]  bram_wdata;
  logic          bram_re;
  logic [AW-1:0] bram_raddr;
  logic [W-1:0]  bram_rdata = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [SW-1:0] checksum;

  activation_lut_loader #(
    .LUT_ADDR_SIZE(AW),
    .LUT_DEPTH(DEPTH),
    .LUT_WIDTH(W),
    .SUM_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bram_we(bram_we), .bram_waddr(bram_waddr),
    .bram_wdata(bram_wdata), .bram_re(bram_re), .bram_raddr(bram_raddr),
    .bram_rdata(bram_rdata), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency BRAM; optionally flips bit0 of address 7 on readback
  logic [W-1:0] mem [DEPTH];
  bit corrupt = 1'b0;
  always @(posedge clk) begin
    if (bram_we) mem[bram_waddr] <= bram_wdata;
    if (bram_re) bram_rdata <= mem[bram_raddr] ^ ((corrupt && bram_raddr == AW'(7)) ? W'(1) : W'(0));
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: loading flag, accepted-entry table, and a timeline
  // counter m_after = cycles elapsed since the last handshake.
  bit m_ok = 0;
  bit m_loading = 0;
  int m_cnt = 0;
  int m_sum = 0;
  int m_after = -1;
  bit m_we = 0;
  int m_waddr = 0;
  int m_wdata = 0;
  bit m_err = 0;
  int tbl [DEPTH];

  function automatic bit m_busy();
    return m_loading || (m_after >= 1 && m_after <= int'(DEPTH) + 1);
  endfunction
  function automatic bit m_done();
    return m_after == int'(DEPTH) + 2;
  endfunction
  function automatic bit m_re();
    return m_after >= 1 && m_after <= int'(DEPTH);
  endfunction
  function automatic int rb_sum();
    int s = 0;
    for (int k = 0; k < int'(DEPTH); k++) s += tbl[k] ^ ((corrupt && k == 7) ? 1 : 0);
    return s;
  endfunction

  initial forever begin
    bit hs, go;
    @(posedge clk);
    if (rst) begin
      m_ok = 1; m_loading = 0; m_cnt = 0; m_sum = 0; m_after = -1; m_we = 0; m_err = 0;
    end else begin
      go = start && !m_busy();
      hs = m_loading && in_valid;
      m_we = hs;
      if (hs) begin
        m_waddr = m_cnt;
        m_wdata = int'(in_data);
        tbl[m_cnt] = int'(in_data);
        m_sum += int'(in_data);
        m_cnt++;
        if (m_cnt == int'(DEPTH)) begin
          m_loading = 0;
          m_after = 1;
        end
      end else if (m_after >= 1 && m_after < int'(DEPTH) + 2) begin
        m_after++;
        if (m_after == int'(DEPTH) + 2) m_err = (rb_sum() != m_sum);
      end
      if (go) begin
        m_loading = 1; m_cnt = 0; m_sum = 0; m_after = -1; m_err = 0;
      end
    end
  end

  int wr_count = 0;
  int done_rises = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;
  bit done_prev = 0;

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("in_ready", int'(in_ready), int'(m_loading));
      chk("busy", int'(busy), int'(m_busy()));
      chk("done", int'(done), int'(m_done()));
      chk("bram_we", int'(bram_we), int'(m_we));
      if (m_we) begin
        chk("bram_waddr", int'(bram_waddr), m_waddr);
        chk("bram_wdata", int'(bram_wdata), m_wdata);
      end
      chk("bram_re", int'(bram_re), int'(m_re()));
      if (m_re()) chk("bram_raddr", int'(bram_raddr), m_after - 1);
      chk("checksum", int'(checksum), m_sum);
      if (m_done()) chk("error", int'(error), int'(m_err));
      if (bram_we) wr_count++;
      if (done && !done_prev) begin
        done_rises++;
        done_cyc = cyc;
      end
      done_prev = done;
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 valid pattern 1,0,0,1,..., 2 random gaps
  task automatic stream(input int gap_mode, input bit rnd_data, input int start_at,
                        input int rst_at, output int sum);
    sum = 0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      int gaps;
      gaps = (gap_mode == 1) ? ((k == 0) ? 0 : 2) :
             (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (gaps) begin
        @(negedge clk); in_valid = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = rnd_data ? W'($urandom) : W'(k * 31);
      start    = (k == start_at);
      last_hs_cyc = cyc;
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; start = 1'b0;
        return;
      end
      sum += int'(in_data);
    end
    @(negedge clk); in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 100 cycles");
    end
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset state
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(bram_we), 0);
    chk("rst_re", int'(bram_re), 0);
    chk("rst_checksum", int'(checksum), 0);
    chk("rst_error", int'(error), 0);

    // start with no valid data: stays in LOAD, nothing written
    do_start();
    wr_count = 0;
    repeat (20) @(negedge clk);
    chk("idle_load_in_ready", int'(in_ready), 1);
    chk("idle_load_writes", wr_count, 0);
    do_reset();

    // back-to-back k*31
    do_start();
    wr_count = 0; done_rises = 0;
    stream(0, 1'b0, -1, -1, s);
    wait_done();
    chk("b2b_checksum", int'(checksum), 3720);
    chk("b2b_error", int'(error), 0);
    chk("b2b_latency", done_cyc - last_hs_cyc, 18);
    chk("b2b_writes", wr_count, 16);
    for (int k = 0; k < int'(DEPTH); k++) chk("b2b_mem", int'(mem[k]), k * 31);

    // gapped 1,0,0 valid pattern
    do_start();
    wr_count = 0;
    stream(1, 1'b0, -1, -1, s);
    wait_done();
    chk("gap_checksum", int'(checksum), 3720);
    chk("gap_writes", wr_count, 16);
    chk("gap_error", int'(error), 0);
    for (int k = 0; k < int'(DEPTH); k += 5) chk("gap_mem", int'(mem[k]), k * 31);

    // corrupted readback
    corrupt = 1'b1;
    do_start();
    stream(0, 1'b0, -1, -1, s);
    wait_done();
    chk("corrupt_error", int'(error), 1);
    chk("corrupt_checksum", int'(checksum), 3720);
    corrupt = 1'b0;

    // start pulses while busy are ignored
    do_start();
    wr_count = 0; done_rises = 0;
    stream(0, 1'b0, 5, -1, s);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("busy_start_writes", wr_count, 16);
    chk("busy_start_dones", done_rises, 1);
    chk("busy_start_error", int'(error), 0);

    // reset mid-load at k=9
    do_start();
    stream(0, 1'b0, -1, 9, s);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_we", int'(bram_we), 0);
    chk("midrst_done", int'(done), 0);
    do_start();
    stream(2, 1'b1, -1, -1, s);
    wait_done();
    chk("midrst_reload_error", int'(error), 0);
    chk("midrst_reload_sum", int'(checksum), s);

    // restart from DONE
    do_start();
    chk("restart_done", int'(done), 0);
    chk("restart_error", int'(error), 0);
    chk("restart_checksum", int'(checksum), 0);
    chk("restart_in_ready", int'(in_ready), 1);
    stream(2, 1'b1, -1, -1, s);
    wait_done();
    chk("restart_sum", int'(checksum), s);
    chk("restart_error_final", int'(error), 0);

    // a few more randomized loads, some with corruption
    for (int r = 0; r < 4; r++) begin
      corrupt = bit'($urandom_range(0, 1));
      do_start();
      wr_count = 0;
      stream(2, 1'b1, -1, -1, s);
      wait_done();
      chk("rnd_sum", int'(checksum), s);
      chk("rnd_writes", wr_count, 16);
      chk("rnd_error", int'(error), int'(corrupt));
    end
    corrupt = 1'b0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
